keyset_direction_decoder: RTL and testbench

KEYSET_DIRECTION_DECODER -- requirements
Module: keyset_direction_decoder

---
 rtl/keyset_direction_decoder.sv | 152 +++++++++++++++
 tb/tb_keyset_direction_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keyset_direction_decoder.sv
// PS/2 scancode to per-player heading decoder with E0/F0 prefix tracking,
// reverse/repeat suppression and a space-key pause toggle.
module keyset_direction_decoder #(
  parameter int          NUM_PLAYERS    = 2,
  parameter logic [7:0]  INIT_DIR       = 8'({2'b11, 2'b01}),
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               scan_code,
  input  logic                     scan_valid,
  input  logic [3*NUM_PLAYERS-1:0] keyset,
  output logic [2*NUM_PLAYERS-1:0] dir,
  output logic [NUM_PLAYERS-1:0]   dir_changed,
  output logic                     paused
);

  // state   | meaning
  // IDLE    | no prefix pending
  // EXT     | E0 seen, next byte is an extended make
  // BRK     | F0 seen, next byte is a break
  // EXT_BRK | E0 F0 seen, next byte is an extended break
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  state_t                     state, state_eff, state_nxt;
  logic [15:0]                tmo_cnt;
  logic                       is_make, is_ext, pause_tgl;
  logic [2*NUM_PLAYERS-1:0]   dir_nxt;
  logic [NUM_PLAYERS-1:0]     chg_nxt;

  // {hit, heading} for a make code under a keyset; keysets 4-7 alias keyset 2
  function automatic logic [2:0] lookup(input logic [2:0] ks, input logic [7:0] code,
                                        input logic ext);
    logic [2:0] r;
    r = 3'b000;
    case (ks)
      3'd0: if (!ext) begin
        case (code)
          8'h1C:   r = {1'b1, LEFT};
          8'h23:   r = {1'b1, RIGHT};
          8'h1D:   r = {1'b1, UP};
          8'h1B:   r = {1'b1, DOWN};
          default: r = 3'b000;
        endcase
      end
      3'd1: if (!ext) begin
        case (code)
          8'h2B:   r = {1'b1, LEFT};
          8'h33:   r = {1'b1, RIGHT};
          8'h2C:   r = {1'b1, UP};
          8'h34:   r = {1'b1, DOWN};
          default: r = 3'b000;
        endcase
      end
      3'd3: if (ext) begin
        case (code)
          8'h6B:   r = {1'b1, LEFT};
          8'h74:   r = {1'b1, RIGHT};
          8'h75:   r = {1'b1, UP};
          8'h72:   r = {1'b1, DOWN};
          default: r = 3'b000;
        endcase
      end
      default: if (!ext) begin
        case (code)
          8'h3B:   r = {1'b1, LEFT};
          8'h4B:   r = {1'b1, RIGHT};
          8'h43:   r = {1'b1, UP};
          8'h42:   r = {1'b1, DOWN};
          default: r = 3'b000;
        endcase
      end
    endcase
    return r;
  endfunction

  // An expired prefix is treated as IDLE in the same cycle the count is reached
  always_comb begin
    state_eff = state;
    if (state != IDLE && tmo_cnt >= PREFIX_TIMEOUT) state_eff = IDLE;
  end

  always_comb begin
    state_nxt = state_eff;
    is_make   = 1'b0;
    is_ext    = 1'b0;
    if (scan_valid) begin
      case (state_eff)
        IDLE: begin
          if (scan_code == CODE_EXT)      state_nxt = EXT;
          else if (scan_code == CODE_BRK) state_nxt = BRK;
          else                            is_make   = 1'b1;
        end
        EXT: begin
          if (scan_code == CODE_EXT)      state_nxt = EXT;
          else if (scan_code == CODE_BRK) state_nxt = EXT_BRK;
          else begin
            state_nxt = IDLE;
            is_make   = 1'b1;
            is_ext    = 1'b1;
          end
        end
        default: begin
          if (scan_code != CODE_BRK) state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    logic [2:0] hit;
    dir_nxt   = dir;
    chg_nxt   = '0;
    hit       = 3'b000;
    pause_tgl = is_make && !is_ext && (scan_code == CODE_SPACE);
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hit = lookup(keyset[3*i +: 3], scan_code, is_ext);
      if (is_make && hit[2] && (hit[1:0] != dir[2*i +: 2]) &&
          (hit[1:0] != (dir[2*i +: 2] ^ 2'b10))) begin
        dir_nxt[2*i +: 2] = hit[1:0];
        chg_nxt[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      dir         <= INIT_DIR[2*NUM_PLAYERS-1:0];
      dir_changed <= '0;
      paused      <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      dir_changed <= chg_nxt;
      paused      <= paused ^ pause_tgl;
      if (scan_valid)          tmo_cnt <= '0;
      else if (state != IDLE)  tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_keyset_direction_decoder.sv
// Directed plus randomized bench for keyset_direction_decoder against a
// prefix-flag / lookup-table reference model.
module tb_keyset_direction_decoder;
  localparam int          NP = 2;
  localparam logic [15:0] T  = 16'd20;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    scan_code = 8'h00;
  logic          scan_valid = 1'b0;
  logic [3*NP-1:0] keyset = '0;
  logic [2*NP-1:0] dir;
  logic [NP-1:0]   dir_changed;
  logic            paused;

  keyset_direction_decoder #(.NUM_PLAYERS(NP), .PREFIX_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .keyset(keyset), .dir(dir), .dir_changed(dir_changed), .paused(paused));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: headings indexed up=0,right=1,down=2,left=3; ktab[keyset][heading]
  logic [7:0] ktab [4][4] = '{'{8'h1D, 8'h23, 8'h1B, 8'h1C},
                              '{8'h2C, 8'h33, 8'h34, 8'h2B},
                              '{8'h43, 8'h4B, 8'h42, 8'h3B},
                              '{8'h75, 8'h74, 8'h72, 8'h6B}};
  logic [7:0] pool [20] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2B, 8'h33, 8'h2C, 8'h34,
                            8'h3B, 8'h4B, 8'h43, 8'h42, 8'h6B, 8'h74, 8'h75, 8'h72,
                            8'hE0, 8'hF0, 8'h29, 8'hE0};
  int m_dir [NP];
  int m_chg [NP];
  bit m_pause, pend_e0, pend_f0;
  int gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2*NP-1:0] ed;
    logic [NP-1:0]   ec;
    for (int i = 0; i < NP; i++) begin
      ed[2*i +: 2] = 2'(m_dir[i]);
      ec[i]        = (m_chg[i] != 0);
    end
    chk({tag, ".dir"}, 32'(dir), 32'(ed));
    chk({tag, ".chg"}, 32'(dir_changed), 32'(ec));
    chk({tag, ".paused"}, 32'(paused), 32'(m_pause));
  endtask

  task automatic model_reset();
    m_dir[0] = 1; m_dir[1] = 3;
    for (int i = 0; i < NP; i++) m_chg[i] = 0;
    m_pause = 0; pend_e0 = 0; pend_f0 = 0; gap = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int ks, h;
    for (int i = 0; i < NP; i++) m_chg[i] = 0;
    if (gap >= int'(T)) begin pend_e0 = 0; pend_f0 = 0; end
    if (pend_f0) begin
      if (b != 8'hF0) begin pend_f0 = 0; pend_e0 = 0; end
    end else if (b == 8'hE0) pend_e0 = 1;
    else if (b == 8'hF0) pend_f0 = 1;
    else begin
      for (int i = 0; i < NP; i++) begin
        ks = int'(keyset[3*i +: 3]);
        if (ks > 3) ks = 2;
        if (pend_e0 == (ks == 3)) begin
          for (int j = 0; j < 4; j++) begin
            h = j;
            if (ktab[ks][j] == b && h != m_dir[i] && h != (m_dir[i] + 2) % 4) begin
              m_dir[i] = h;
              m_chg[i] = 1;
            end
          end
        end
      end
      if (!pend_e0 && b == 8'h29) m_pause = !m_pause;
      pend_e0 = 0;
    end
    gap = 0;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    scan_code = b;
    scan_valid = 1'b1;
    @(posedge clock); #1;
    scan_valid = 1'b0;
    model_byte(b);
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NP; i++) m_chg[i] = 0;
      gap++;
      check_all("idle");
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("reset_async");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_all("reset_state");

    keyset = {3'd3, 3'd0};
    send(8'h1D, "p0_up");
    idle(1);
    send(8'h74, "no_e0");
    send(8'hE0, "e0");
    send(8'h74, "reverse");
    send(8'hE0, "e0");
    send(8'h75, "p1_up");
    send(8'h1C, "p0_left");
    send(8'hF0, "f0");
    send(8'h1D, "break");
    send(8'h1B, "make_after_brk");
    send(8'h1B, "repeat");

    keyset = {3'd1, 3'd1};
    send(8'h33, "both_right");
    send(8'h34, "both_down");
    chk("both_pulse", 32'(dir_changed), 32'h3);

    keyset = {3'd3, 3'd5};
    send(8'hE0, "e0");
    idle(int'(T));
    send(8'h6B, "timed_out");
    send(8'hE0, "e0");
    idle(int'(T) - 1);
    send(8'h6B, "before_timeout");
    send(8'hE0, "e0");
    send(8'hE0, "e0_again");
    send(8'hF0, "ext_brk");
    send(8'hF0, "ext_brk_f0");
    send(8'h75, "ext_break");
    send(8'h3B, "ks5_left");

    send(8'h29, "pause_on");
    send(8'hF0, "f0");
    send(8'h29, "space_break");
    send(8'h29, "pause_off");
    send(8'h29, "pause_on2");
    send(8'h43, "dir_while_paused");
    send(8'hE0, "e0");
    do_reset();
    send(8'h75, "after_reset");

    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) keyset = 6'($urandom_range(0, 63));
      else if (r < 8) do_reset();
      else if (r < 16) idle(int'($urandom_range(0, int'(T) + 3)));
      else if (r < 20) send(8'($urandom_range(0, 255)), "rand_any");
      else send(pool[$urandom_range(0, 19)], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
